ps2_scancode_decoder: RTL and testbench



---
 rtl/ps2_scancode_decoder.sv | 184 ++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set 2 scan-code decoder: strips E0/F0/E1 prefixes, emits key events, tracks held game keys.
// Optional REPEAT_FILTER_EN suppresses typematic repeats of tracked keys.
module ps2_scancode_decoder #(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int TW             = 22
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [9:0] keys_held,
    output logic       seq_error
);

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } state_t;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    skip_cnt;
    logic [2:0]    skip_nxt;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_nxt;
    logic          expired;
    logic          emit;
    logic          emit_ext;
    logic          emit_brk;
    logic          fire;
    logic [9:0]    mask;
    logic [9:0]    keys_nxt;

    function automatic logic [9:0] key_mask(input logic [7:0] code,
                                            input logic       ext);
        logic [9:0] m;
        m = '0;
        if (!ext) begin
            case (code)
                8'h1D:   m[0] = 1'b1;
                8'h1C:   m[1] = 1'b1;
                8'h1B:   m[2] = 1'b1;
                8'h23:   m[3] = 1'b1;
                8'h29:   m[4] = 1'b1;
                8'h5A:   m[9] = 1'b1;
                default: m = '0;
            endcase
        end else begin
            case (code)
                8'h75:   m[5] = 1'b1;
                8'h6B:   m[6] = 1'b1;
                8'h72:   m[7] = 1'b1;
                8'h74:   m[8] = 1'b1;
                default: m = '0;
            endcase
        end
        return m;
    endfunction

    // Keyboard status/response bytes that never start a key sequence
    function automatic logic is_noise(input logic [7:0] code);
        return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hEE) ||
               (code == 8'hFC) || (code == 8'hFE) || (code == 8'h00) ||
               (code == 8'hFF);
    endfunction

    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        emit      = 1'b0;
        emit_ext  = 1'b0;
        emit_brk  = 1'b0;
        expired   = (state != IDLE) && !scan_valid && (tmo_cnt == TMO_LAST);
        if (scan_valid) begin
            unique case (state)
                IDLE: begin
                    if (scan_code == 8'hE0) begin
                        state_nxt = EXT;
                    end else if (scan_code == 8'hF0) begin
                        state_nxt = BRK;
                    end else if (scan_code == 8'hE1) begin
                        state_nxt = SKIP;
                        skip_nxt  = 3'd7;
                    end else if (!is_noise(scan_code)) begin
                        emit = 1'b1;
                    end
                end
                EXT: begin
                    if (scan_code == 8'hF0) begin
                        state_nxt = EXT_BRK;
                    end else if (scan_code != 8'hE0) begin
                        emit      = 1'b1;
                        emit_ext  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK: begin
                    if (scan_code == 8'hE0) begin
                        state_nxt = EXT_BRK;
                    end else if (scan_code != 8'hF0) begin
                        emit      = 1'b1;
                        emit_brk  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                EXT_BRK: begin
                    if (scan_code != 8'hF0 && scan_code != 8'hE0) begin
                        emit      = 1'b1;
                        emit_ext  = 1'b1;
                        emit_brk  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                SKIP: begin
                    skip_nxt = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) begin
                        skip_nxt  = 3'd0;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (expired) begin
            state_nxt = IDLE;
            skip_nxt  = 3'd0;
        end
    end

    always_comb begin
        tmo_nxt = tmo_cnt + 1'b1;
        if (scan_valid || state == IDLE || expired) begin
            tmo_nxt = '0;
        end
    end

    always_comb begin
        mask     = key_mask(scan_code, emit_ext);
        keys_nxt = keys_held;
        if (emit) begin
            keys_nxt = emit_brk ? (keys_held & ~mask) : (keys_held | mask);
        end
`ifdef REPEAT_FILTER_EN
        fire = emit && !(!emit_brk && |(mask & keys_held));
`else
        fire = emit;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            skip_cnt  <= '0;
            tmo_cnt   <= '0;
            evt_valid <= 1'b0;
            evt_code  <= '0;
            evt_ext   <= 1'b0;
            evt_break <= 1'b0;
            keys_held <= '0;
            seq_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            skip_cnt  <= skip_nxt;
            tmo_cnt   <= tmo_nxt;
            evt_valid <= fire;
            seq_error <= expired;
            keys_held <= keys_nxt;
            if (fire) begin
                evt_code  <= scan_code;
                evt_ext   <= emit_ext;
                evt_break <= emit_brk;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: expected events queued at
// stimulus time, popped when evt_valid fires.
module tb_ps2_scancode_decoder;

    logic       clk;
    logic       reset;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic [9:0] keys_held;
    logic       seq_error;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [9:0] keys;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_evt   = 0;
    int   n_err   = 0;

    ps2_scancode_decoder #(
        .TIMEOUT_CYCLES(100),
        .TW            (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scan_valid(scan_valid),
        .scan_code (scan_code),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_break (evt_break),
        .keys_held (keys_held),
        .seq_error (seq_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_evt(input logic [7:0] code, input logic ext,
                              input logic brk, input logic [9:0] keys);
        exp_t e;
        e.code = code;
        e.ext  = ext;
        e.brk  = brk;
        e.keys = keys;
        sb.push_back(e);
    endtask

    // Caller sits on a negedge; byte is sampled on the following posedge
    task automatic send(input logic [7:0] b);
        scan_valid = 1'b1;
        scan_code  = b;
        @(negedge clk);
        scan_valid = 1'b0;
        scan_code  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        idle(3);
        check(tag, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (evt_valid) begin
            n_evt++;
            if (sb.size() == 0) begin
                check("spurious_evt", 32'(evt_valid), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("evt_code", 32'(evt_code), 32'(e.code));
                check("evt_ext", 32'(evt_ext), 32'(e.ext));
                check("evt_break", 32'(evt_break), 32'(e.brk));
                check("keys_held", 32'(keys_held), 32'(e.keys));
            end
        end
        if (seq_error) n_err++;
    end

    initial begin
        int n;
        int ev0;
        reset      = 1'b1;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        idle(3);
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_code", 32'(evt_code), 0);
        check("rst_keys", 32'(keys_held), 0);
        check("rst_err", 32'(seq_error), 0);
        reset = 1'b0;
        idle(2);

        expect_evt(8'h1D, 1'b0, 1'b0, 10'h001);
        send(8'h1D);
        idle(5);
        check("valid_pulse", 32'(evt_valid), 0);
        check("code_hold", 32'(evt_code), 32'h1D);
        idle(1000);
        expect_evt(8'h1D, 1'b0, 1'b1, 10'h000);
        send(8'hF0);
        send(8'h1D);
        idle(1000);
        drain("q_wasd");

        expect_evt(8'h75, 1'b1, 1'b0, 10'h020);
        send(8'hE0);
        send(8'h75);
        expect_evt(8'h75, 1'b0, 1'b0, 10'h020);
        send(8'h75);
        expect_evt(8'h75, 1'b0, 1'b1, 10'h020);
        send(8'hF0);
        send(8'h75);
        expect_evt(8'h75, 1'b1, 1'b1, 10'h000);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        drain("q_arrow");

        ev0 = n_evt;
        send(8'hE1);
        send(8'h14);
        send(8'h77);
        send(8'hE1);
        send(8'hF0);
        send(8'h14);
        send(8'hF0);
        send(8'h77);
        idle(3);
        check("pause_no_evt", n_evt - ev0, 0);
        expect_evt(8'h29, 1'b0, 1'b0, 10'h010);
        send(8'h29);
        expect_evt(8'h29, 1'b0, 1'b1, 10'h000);
        send(8'hF0);
        send(8'h29);
        drain("q_pause");

        send(8'hF0);
        n = 0;
        while (!seq_error && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", n, 100);
        @(negedge clk);
        check("tmo_pulse", 32'(seq_error), 0);
        expect_evt(8'h1C, 1'b0, 1'b0, 10'h002);
        send(8'h1C);
        drain("q_tmo");
        expect_evt(8'h1C, 1'b0, 1'b1, 10'h000);
        send(8'hF0);
        idle(99);
        send(8'h1C);
        idle(120);
        check("tmo_edge_err", n_err, 1);
        drain("q_tmo_edge");

        ev0 = n_evt;
        send(8'hAA);
        send(8'hFA);
        send(8'hEE);
        idle(3);
        check("noise_no_evt", n_evt - ev0, 0);
        ev0 = n_evt;
        expect_evt(8'h1D, 1'b0, 1'b0, 10'h001);
`ifndef REPEAT_FILTER_EN
        expect_evt(8'h1D, 1'b0, 1'b0, 10'h001);
        expect_evt(8'h1D, 1'b0, 1'b0, 10'h001);
`endif
        send(8'h1D);
        send(8'h1D);
        send(8'h1D);
        idle(3);
`ifdef REPEAT_FILTER_EN
        check("repeat_cnt", n_evt - ev0, 1);
`else
        check("repeat_cnt", n_evt - ev0, 3);
`endif
        expect_evt(8'h1D, 1'b0, 1'b1, 10'h000);
        send(8'hF0);
        send(8'h1D);
        drain("q_repeat");

        expect_evt(8'h6B, 1'b1, 1'b0, 10'h040);
        send(8'hE0);
        send(8'h6B);
        expect_evt(8'h72, 1'b1, 1'b0, 10'h0C0);
        send(8'hE0);
        send(8'h72);
        expect_evt(8'h74, 1'b1, 1'b0, 10'h1C0);
        send(8'hE0);
        send(8'h74);
        expect_evt(8'h5A, 1'b0, 1'b0, 10'h3C0);
        send(8'h5A);
        expect_evt(8'h1B, 1'b0, 1'b0, 10'h3C4);
        send(8'h1B);
        expect_evt(8'h23, 1'b0, 1'b0, 10'h3CC);
        send(8'h23);
        expect_evt(8'h1D, 1'b0, 1'b0, 10'h3CD);
        send(8'h1D);
        expect_evt(8'h1C, 1'b0, 1'b0, 10'h3CF);
        send(8'h1C);
        send(8'hE0);
        send(8'hF0);
        drain("q_map");

        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(evt_valid), 0);
        check("mid_rst_code", 32'(evt_code), 0);
        check("mid_rst_ext", 32'(evt_ext), 0);
        check("mid_rst_brk", 32'(evt_break), 0);
        check("mid_rst_keys", 32'(keys_held), 0);
        check("mid_rst_err", 32'(seq_error), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        expect_evt(8'h23, 1'b0, 1'b0, 10'h008);
        send(8'h23);
        drain("q_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
